dp_access_ctrl: RTL and testbench
=================================

Name: dp_access_ctrl

Overview:
- Access initiator for the bare dual-port memory tile. It drives the tile's wen_in/waddr/data_in and ren_in/raddr ports.
- Each side (write, read) runs an independent affine address pattern of up to 3 dimensions. The read side is released a configured number of cycles after start.
- Realigns tile data_out with a valid strobe to cover the tile's 1-cycle registered read latency.
- Sits between the CGRA stream fabric and one memory tile instance.

Parameters:
- ADDR_W, 16, tile address port width (tile consumes low 9 bits)
- DATA_W, 16, data word width
- DIMS, 3, maximum loop-nest depth per side
- CNT_W, 16, width of range and delay counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; low freezes all state
- flush  in  1  synchronous soft reset, qualified by clk_en
- start  in  1  pulse; launches one pattern execution
- wr_dim  in  2  write loop depth, 0..DIMS; 0 disables the write side
- wr_start_addr  in  ADDR_W  write base address
- wr_range  in  DIMS*CNT_W  per-dim extent minus 1
- wr_stride  in  DIMS*ADDR_W  per-dim stride, two's complement
- rd_dim, rd_start_addr, rd_range, rd_stride  in  as wr_*  read-side equivalents
- rd_delay  in  CNT_W  cycles from start until the first read
- in_valid  in  1  upstream word available
- in_data  in  DATA_W  upstream word
- in_ready  out  1  write side will consume in_data this cycle
- wen  out  1  to tile wen_in
- waddr  out  ADDR_W  to tile waddr
- wdata  out  DATA_W  to tile data_in
- ren  out  1  to tile ren_in
- raddr  out  ADDR_W  to tile raddr
- tile_rdata  in  DATA_W  from tile data_out
- out_valid  out  1  out_data is valid
- out_data  out  DATA_W  read stream
- busy  out  1  pattern in progress
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset, or flush with clk_en high: all outputs 0, FSM in IDLE, all counters 0, delay counter 0.
- Config ports are static while busy=1. Changing them mid-run is undefined.
- Top FSM states:
  - IDLE: on start=1 & clk_en=1, go to ACTIVE. Load both address generators with idx=0 and addr=start_addr. Load delay counter with rd_delay.
  - ACTIVE: leave when wr_fin & rd_fin & no read in flight, going to DONE.
  - DONE: assert done=1 for one cycle, then return to IDLE.
  - busy=1 in ACTIVE and DONE.
- start while busy: ignored. start and flush in the same cycle: flush wins.
- Write side:
  - in_ready = ACTIVE & ~wr_fin & clk_en.
  - wen = in_valid & in_ready; waddr = current write address; wdata = in_data, combinational pass-through.
  - The generator advances only on wen. After the last iteration, wr_fin is set and sticky until IDLE.
- Read side:
  - The delay counter decrements each enabled ACTIVE cycle until it reaches 0. ren = ACTIVE & delay==0 & ~rd_fin & clk_en.
  - With rd_delay=0, the first ren occurs in the first ACTIVE cycle.
  - The generator advances on each ren. There is no backpressure.
- Read latency: out_valid is ren registered by one enabled cycle. out_data = tile_rdata, passed through when out_valid=1 and 0 otherwise.
- Address arithmetic: addr = start_addr + Σ idx_i*stride_i, modulo 2^ADDR_W. Negative strides and wrap-around are legal. Computed incrementally, with no multipliers.
- Loop order: dim 0 is innermost. When idx_0 == range_0, idx_0 goes to 0 and idx_1 increments, and so on. Finish occurs when every active dim is at its range on an advance.
- Total accesses per side = Π(range_i+1) over active dims. A side with dim=0 is finished immediately.
- clk_en=0: all registers hold, and wen, ren and in_ready are forced to 0.
- Reset mid-operation: immediate return to IDLE; no done pulse.

Decomposition:
- Package dp_access_pkg holds DIMS, ADDR_W, DATA_W, CNT_W and the FSM enum {IDLE, ACTIVE, DONE}.
- Sub-module affine_addr_gen holds the per-dim index counters, the running address and the fin flag, with init/step inputs. It is instantiated twice, once per side.

Test Plan:
- 1-D write, wr_dim=1, range=7, stride=1, base=0x10, in_valid always 1 → wen for 8 cycles, waddr 0x10..0x17, then wr_fin.
- 2-D read, rd_dim=2, range={3,1}, stride={1,16}, base=0, rd_delay=4 → first ren 4 cycles after start. raddr sequence 0,1,2,3,16,17,18,19. out_valid trails ren by 1 and out_data matches the tile contents. done pulses once.
- Write gaps: in_valid toggles 1,0,1,0 → wen only on valid cycles, the address does not advance on gaps, and exactly 8 writes are issued.
- Negative stride with wrap: base=0x0002, stride=0xFFFF, range=3 → raddr 0x0002, 0x0001, 0x0000, 0xFFFF.
- clk_en low for 3 cycles mid-read → ren=0 and all state is frozen. The sequence resumes with no skipped or duplicated address.
- Flush mid-ACTIVE, together with a start in the same cycle → IDLE, busy=0, no done pulse. A following start restarts from base.

Source files
------------

// File: rtl/dp_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the dual-port tile access controller.
package dp_access_pkg;

    localparam int DIMS   = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dp_access_ctrl_if.sv
// Data-path bundle between the access controller, the upstream/downstream
// stream fabric and the memory tile ports.
interface dp_access_ctrl_if #(
    parameter int ADDR_W = dp_access_pkg::ADDR_W,
    parameter int DATA_W = dp_access_pkg::DATA_W
) ();

    // upstream write stream
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    // tile ports
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] tile_rdata;
    // downstream read stream
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_valid, in_data, tile_rdata,
        output in_ready, wen, waddr, wdata, ren, raddr, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, tile_rdata,
        input  in_ready, wen, waddr, wdata, ren, raddr, out_valid, out_data
    );

endinterface

// File: rtl/dp_access_ctrl_addr_gen.sv
// Incremental affine address generator, up to DIMS nested loops, dim 0
// innermost. Keeps one base address per dim (the address with all inner
// indices at zero) so a carry into dim k is a single add, no multipliers.
module affine_addr_gen import dp_access_pkg::*; #(
    parameter int DIMS   = dp_access_pkg::DIMS,
    parameter int ADDR_W = dp_access_pkg::ADDR_W,
    parameter int CNT_W  = dp_access_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   clr,
    input  logic                   init,
    input  logic                   step,
    input  logic [1:0]             dim,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [DIMS*CNT_W-1:0]  range,
    input  logic [DIMS*ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0]      addr,
    output logic                   fin
);

    logic [DIMS-1:0][CNT_W-1:0]  range_a;
    logic [DIMS-1:0][ADDR_W-1:0] stride_a;
    logic [DIMS-1:0][CNT_W-1:0]  idx, nxt_idx;
    logic [DIMS-1:0][ADDR_W-1:0] base, nxt_base;
    logic [DIMS-1:0]             at_end, sel, below;
    logic                        last;
    logic [ADDR_W-1:0]           step_addr;

    assign range_a  = range;
    assign stride_a = stride;
    assign addr     = base[0];

    // Pick the innermost dim with iterations left; everything inside it rewinds
    // to that dim's new base. Inactive dims always look finished.
    always_comb begin : nxt_calc
        logic carry;
        logic hi;
        carry     = 1'b1;
        hi        = 1'b0;
        at_end    = '0;
        sel       = '0;
        below     = '0;
        step_addr = '0;
        nxt_idx   = idx;
        nxt_base  = base;
        for (int i = 0; i < DIMS; i++) begin
            at_end[i] = (i < int'(dim)) ? (idx[i] == range_a[i]) : 1'b1;
            sel[i]    = carry & ~at_end[i];
            carry     = carry & at_end[i];
        end
        last = carry;
        for (int i = DIMS - 1; i >= 0; i--) begin
            below[i] = hi;
            hi       = hi | sel[i];
        end
        for (int i = 0; i < DIMS; i++) begin
            if (sel[i]) step_addr = base[i] + stride_a[i];
        end
        for (int i = 0; i < DIMS; i++) begin
            if (sel[i]) begin
                nxt_idx[i]  = idx[i] + 1'b1;
                nxt_base[i] = step_addr;
            end else if (below[i]) begin
                nxt_idx[i]  = '0;
                nxt_base[i] = step_addr;
            end
        end
    end

    // Index/base registers; fin is sticky until the next init or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            base <= '0;
            fin  <= 1'b0;
        end else if (clk_en) begin
            if (clr) begin
                idx  <= '0;
                base <= '0;
                fin  <= 1'b0;
            end else if (init) begin
                idx  <= '0;
                base <= {DIMS{start_addr}};
                fin  <= (dim == 2'd0);
            end else if (step && !fin) begin
                if (last) begin
                    fin <= 1'b1;
                end else begin
                    idx  <= nxt_idx;
                    base <= nxt_base;
                end
            end
        end
    end

endmodule

// File: rtl/dp_access_ctrl.sv
// Access initiator for one dual-port memory tile: independent affine write
// and read patterns, delayed read release, and read-data realignment for the
// tile's one-cycle registered read. Tile uses only the low 9 address bits.
module dp_access_ctrl import dp_access_pkg::*; #(
    parameter int ADDR_W = dp_access_pkg::ADDR_W,
    parameter int DATA_W = dp_access_pkg::DATA_W,
    parameter int DIMS   = dp_access_pkg::DIMS,
    parameter int CNT_W  = dp_access_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   start,
    input  logic [1:0]             wr_dim,
    input  logic [ADDR_W-1:0]      wr_start_addr,
    input  logic [DIMS*CNT_W-1:0]  wr_range,
    input  logic [DIMS*ADDR_W-1:0] wr_stride,
    input  logic [1:0]             rd_dim,
    input  logic [ADDR_W-1:0]      rd_start_addr,
    input  logic [DIMS*CNT_W-1:0]  rd_range,
    input  logic [DIMS*ADDR_W-1:0] rd_stride,
    input  logic [CNT_W-1:0]       rd_delay,
    output logic                   busy,
    output logic                   done,
    dp_access_ctrl_if.master       bus
);

    state_t            state;
    logic [CNT_W-1:0]  dly;
    logic              done_r;
    logic              ovld;
    logic              wr_fin, rd_fin;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              active, launch, in_ready_i, wen_i, ren_i;

    assign active     = (state == ACTIVE);
    assign launch     = (state == IDLE) & start & clk_en & ~flush;
    assign in_ready_i = active & ~wr_fin & clk_en;
    assign wen_i      = bus.in_valid & in_ready_i;
    assign ren_i      = active & (dly == '0) & ~rd_fin & clk_en;

    assign bus.in_ready  = in_ready_i;
    assign bus.wen       = wen_i;
    assign bus.waddr     = wr_addr;
    assign bus.wdata     = bus.in_data;
    assign bus.ren       = ren_i;
    assign bus.raddr     = rd_addr;
    assign bus.out_valid = ovld;
    assign bus.out_data  = ovld ? bus.tile_rdata : '0;
    assign busy          = (state != IDLE);
    assign done          = done_r;

    affine_addr_gen #(.DIMS(DIMS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_wr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clr        (flush),
        .init       (launch),
        .step       (wen_i),
        .dim        (wr_dim),
        .start_addr (wr_start_addr),
        .range      (wr_range),
        .stride     (wr_stride),
        .addr       (wr_addr),
        .fin        (wr_fin)
    );

    affine_addr_gen #(.DIMS(DIMS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rd_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clr        (flush),
        .init       (launch),
        .step       (ren_i),
        .dim        (rd_dim),
        .start_addr (rd_start_addr),
        .range      (rd_range),
        .stride     (rd_stride),
        .addr       (rd_addr),
        .fin        (rd_fin)
    );

    // Top FSM with read-delay countdown and one-cycle read realignment.
    // ovld doubles as the "read in flight" flag holding off completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dly    <= '0;
            done_r <= 1'b0;
            ovld   <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state  <= IDLE;
                dly    <= '0;
                done_r <= 1'b0;
                ovld   <= 1'b0;
            end else begin
                ovld   <= ren_i;
                done_r <= 1'b0;
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= ACTIVE;
                            dly   <= rd_delay;
                        end
                    end
                    ACTIVE: begin
                        if (dly != '0) dly <= dly - 1'b1;
                        if (wr_fin && rd_fin && !ovld) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dp_access_ctrl.sv
// Scoreboard bench: directed patterns push expected tile writes, read
// addresses and read data; a negedge monitor pops and compares them.
module tb_dp_access_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_ent_t;

    logic        clk, rst_n, clk_en, flush, start;
    logic [1:0]  wr_dim, rd_dim;
    logic [15:0] wr_start_addr, rd_start_addr, rd_delay;
    logic [47:0] wr_range, wr_stride, rd_range, rd_stride;
    logic        busy, done;

    dp_access_ctrl_if bus ();

    dp_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .flush         (flush),
        .start         (start),
        .wr_dim        (wr_dim),
        .wr_start_addr (wr_start_addr),
        .wr_range      (wr_range),
        .wr_stride     (wr_stride),
        .rd_dim        (rd_dim),
        .rd_start_addr (rd_start_addr),
        .rd_range      (rd_range),
        .rd_stride     (rd_stride),
        .rd_delay      (rd_delay),
        .busy          (busy),
        .done          (done),
        .bus           (bus)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    wr_ent_t     wq[$];
    logic [15:0] raq[$];
    logic [15:0] rdq[$];
    logic [15:0] mem [512];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tile model: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.wen) mem[bus.waddr[8:0]] <= bus.wdata;
        if (bus.ren) bus.tile_rdata <= mem[bus.raddr[8:0]];
    end

    // Monitor: pop expected items whenever the DUT presents them.
    always @(negedge clk) begin
        wr_ent_t e;
        if (rst_n) begin
            if (bus.wen) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("waddr", bus.waddr, e.a);
                    chk("wdata", bus.wdata, e.d);
                end
            end
            if (bus.ren) begin
                if (raq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("raddr", bus.raddr, raq.pop_front());
            end
            if (bus.out_valid && clk_en) begin
                if (rdq.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_data", bus.out_data, rdq.pop_front());
            end
            if (done && clk_en) done_cnt++;
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_ent_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic push_rd(input logic [15:0] a, input logic [15:0] d);
        raq.push_back(a);
        rdq.push_back(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer n words; in gap mode valid only on even cycles. Returns cycles used.
    task automatic feed(input int n, input bit gaps, input logic [15:0] dbase, output int cyc);
        int  k;
        bit  acc;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 100) begin
            bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = dbase + 16'(k);
            @(negedge clk);
            acc = bus.wen;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk("feed_count", k, n);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_1cyc"}, done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int cyc;
        for (int i = 0; i < 512; i++) mem[i] = 16'h5000 ^ 16'(i);
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        wr_dim = '0; rd_dim = '0; wr_start_addr = '0; rd_start_addr = '0;
        wr_range = '0; wr_stride = '0; rd_range = '0; rd_stride = '0; rd_delay = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wen", bus.wen, 0);
        chk("rst_ren", bus.ren, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_raddr", bus.raddr, 0);
        @(posedge clk); #1;

        // 1-D write, 8 words at 0x10..0x17
        wr_dim = 2'd1; wr_start_addr = 16'h0010;
        wr_range = {16'd0, 16'd0, 16'd7}; wr_stride = {16'd0, 16'd0, 16'd1};
        rd_dim = 2'd0;
        for (int i = 0; i < 8; i++) push_wr(16'h0010 + 16'(i), 16'hA000 + 16'(i));
        pulse_start();
        feed(8, 1'b0, 16'hA000, cyc);
        chk("t1_cycles", cyc, 8);
        chk("t1_in_ready_off", bus.in_ready, 0);
        wait_done("t1");

        // 2-D read with delay 4; 0x10..0x13 hold the words just written
        wr_dim = 2'd0; rd_dim = 2'd2; rd_start_addr = 16'h0000; rd_delay = 16'd4;
        rd_range = {16'd0, 16'd1, 16'd3}; rd_stride = {16'd0, 16'd16, 16'd1};
        for (int i = 0; i < 4; i++) push_rd(16'(i), 16'h5000 + 16'(i));
        for (int i = 0; i < 4; i++) push_rd(16'd16 + 16'(i), 16'hA000 + 16'(i));
        pulse_start();
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.ren || n >= 20) break;
            n++;
        end
        chk("t2_first_ren", n, 4);
        wait_done("t2");

        // write with gaps on in_valid
        wr_dim = 2'd1; wr_start_addr = 16'h0040; rd_dim = 2'd0;
        wr_range = {16'd0, 16'd0, 16'd7}; wr_stride = {16'd0, 16'd0, 16'd1};
        for (int i = 0; i < 8; i++) push_wr(16'h0040 + 16'(i), 16'hB000 + 16'(i));
        pulse_start();
        feed(8, 1'b1, 16'hB000, cyc);
        chk("t3_cycles", cyc, 15);
        wait_done("t3");

        // negative stride wrapping below zero
        wr_dim = 2'd0; rd_dim = 2'd1; rd_start_addr = 16'h0002; rd_delay = 16'd0;
        rd_range = {16'd0, 16'd0, 16'd3}; rd_stride = {16'd0, 16'd0, 16'hFFFF};
        push_rd(16'h0002, 16'h5002);
        push_rd(16'h0001, 16'h5001);
        push_rd(16'h0000, 16'h5000);
        push_rd(16'hFFFF, 16'h51FF);
        pulse_start();
        wait_done("t4");

        // 3-D read with clk_en low for 3 cycles after the third read
        rd_dim = 2'd3; rd_start_addr = 16'h0100; rd_delay = 16'd0;
        rd_range = {16'd1, 16'd1, 16'd1}; rd_stride = {16'h0020, 16'h0004, 16'h0001};
        push_rd(16'h0100, 16'h5100); push_rd(16'h0101, 16'h5101);
        push_rd(16'h0104, 16'h5104); push_rd(16'h0105, 16'h5105);
        push_rd(16'h0120, 16'h5120); push_rd(16'h0121, 16'h5121);
        push_rd(16'h0124, 16'h5124); push_rd(16'h0125, 16'h5125);
        pulse_start();
        repeat (3) begin @(posedge clk); #1; end
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_ren_frozen", bus.ren, 0);
            chk("t5_raddr_held", bus.raddr, 16'h0105);
            chk("t5_busy_held", busy, 1);
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        wait_done("t5");

        // flush together with start mid-run, then restart from base
        rd_dim = 2'd1; rd_start_addr = 16'h0030; rd_delay = 16'd10;
        rd_range = {16'd0, 16'd0, 16'd7}; rd_stride = {16'd0, 16'd0, 16'd1};
        pulse_start();
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t6_flush_busy", busy, 0);
        chk("t6_flush_done", done, 0);
        chk("t6_flush_ren", bus.ren, 0);
        @(posedge clk); #1;
        rd_delay = 16'd0; rd_range = {16'd0, 16'd0, 16'd1};
        push_rd(16'h0030, 16'h5030);
        push_rd(16'h0031, 16'h5031);
        pulse_start();
        wait_done("t6");

        chk("done_pulses", done_cnt, 6);
        chk("wq_empty", wq.size(), 0);
        chk("raq_empty", raq.size(), 0);
        chk("rdq_empty", rdq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
